// File: rtl/bht_predictor.sv
// Parametrised branch history table: bimodal or gshare indexing, saturating
// counters, speculative global history with mispredict repair, perf counters.
module bht_predictor #(
   parameter int ENTRIES   = 64,
   parameter int CTR_BITS  = 2,
   parameter int GHR_BITS  = 0,
   parameter int CNT_WIDTH = 32,
   localparam int IDX_BITS = $clog2(ENTRIES),
   localparam int GW       = (GHR_BITS > 0) ? GHR_BITS : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_valid_i,
   input  logic [31:0]          if_pc_i,
   output logic                 pred_taken_o,
   output logic [GW-1:0]        pred_ghr_o,
   input  logic                 upd_valid_i,
   input  logic [31:0]          upd_pc_i,
   input  logic                 upd_taken_i,
   input  logic [GW-1:0]        upd_ghr_i,
   input  logic                 upd_mispredict_i,
   output logic [CNT_WIDTH-1:0] branch_count_o,
   output logic [CNT_WIDTH-1:0] mispredict_count_o
);

   // Weakly not-taken: 0 followed by all ones.
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CTR_BITS-1:0]  table_q [ENTRIES];
   logic [GW-1:0]        ghr_q;
   logic [IDX_BITS-1:0]  lk_hist;
   logic [IDX_BITS-1:0]  up_hist;
   logic [IDX_BITS-1:0]  lk_idx;
   logic [IDX_BITS-1:0]  up_idx;
   logic [CTR_BITS-1:0]  lk_ctr;
   logic [CTR_BITS-1:0]  up_ctr;
   logic [CTR_BITS-1:0]  up_ctr_nxt;
   logic [CNT_WIDTH-1:0] branch_cnt_q;
   logic [CNT_WIDTH-1:0] mispred_cnt_q;
   logic                 repair;

   // History is zero-extended into the index; bimodal leaves it all zero.
   always_comb begin
      lk_hist = '0;
      up_hist = '0;
      if (GHR_BITS > 0) begin
         lk_hist[GW-1:0] = ghr_q;
         up_hist[GW-1:0] = upd_ghr_i;
      end
   end

   assign lk_idx = if_pc_i[IDX_BITS+1:2] ^ lk_hist;
   assign up_idx = upd_pc_i[IDX_BITS+1:2] ^ up_hist;

   assign lk_ctr       = table_q[lk_idx];
   assign pred_taken_o = lk_ctr[CTR_BITS-1];
   assign pred_ghr_o   = ghr_q;

   assign up_ctr = table_q[up_idx];
   assign repair = upd_valid_i & upd_mispredict_i;

   always_comb begin
      up_ctr_nxt = up_ctr;
      if (upd_taken_i) begin
         if (up_ctr != CTR_MAX) begin
            up_ctr_nxt = up_ctr + CTR_BITS'(1);
         end
      end else if (up_ctr != '0) begin
         up_ctr_nxt = up_ctr - CTR_BITS'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            table_q[i] <= CTR_INIT;
         end
      end else if (upd_valid_i) begin
         table_q[up_idx] <= up_ctr_nxt;
      end
   end

   generate
      if (GHR_BITS > 0) begin : g_ghr
         logic [GW-1:0] ghr_nxt;

         // Repair wins over the speculative shift of a same-cycle lookup.
         always_comb begin
            ghr_nxt = ghr_q;
            if (repair) begin
               ghr_nxt = (upd_ghr_i << 1) | GW'(upd_taken_i);
            end else if (if_valid_i) begin
               ghr_nxt = (ghr_q << 1) | GW'(pred_taken_o);
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ghr_q <= '0;
            end else begin
               ghr_q <= ghr_nxt;
            end
         end
      end else begin : g_no_ghr
         assign ghr_q = '0;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (upd_valid_i && branch_cnt_q != CNT_MAX) begin
            branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
         end
         if (repair && mispred_cnt_q != CNT_MAX) begin
            mispred_cnt_q <= mispred_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   assign branch_count_o     = branch_cnt_q;
   assign mispredict_count_o = mispred_cnt_q;

   // PC offset and high bits are deliberately ignored (aliasing allowed).
   logic unused_bits;
   assign unused_bits = ^{if_pc_i[31:IDX_BITS+2], if_pc_i[1:0],
                          upd_pc_i[31:IDX_BITS+2], upd_pc_i[1:0],
                          upd_ghr_i, if_valid_i};

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: a bimodal and a gshare instance driven in parallel,
// checked each cycle against an integer model plus hand-computed expectations.
module tb_bht_predictor;

   logic        clk;
   logic        reset;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [3:0]  upd_ghr;
   logic        upd_mis;

   logic        pred_b;
   logic [0:0]  ghr_b;
   logic [3:0]  bc_b;
   logic [3:0]  mc_b;
   logic        pred_g;
   logic [3:0]  ghr_g;
   logic [31:0] bc_g;
   logic [31:0] mc_g;

   int passed = 0;
   int total  = 0;
   bit chk_on = 0;

   bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .GHR_BITS(0), .CNT_WIDTH(4)) dut_b (
      .clk(clk), .reset(reset),
      .if_valid_i(if_valid), .if_pc_i(if_pc),
      .pred_taken_o(pred_b), .pred_ghr_o(ghr_b),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_ghr_i(1'b0), .upd_mispredict_i(upd_mis),
      .branch_count_o(bc_b), .mispredict_count_o(mc_b)
   );

   bht_predictor #(.ENTRIES(64), .CTR_BITS(2), .GHR_BITS(4), .CNT_WIDTH(32)) dut_g (
      .clk(clk), .reset(reset),
      .if_valid_i(if_valid), .if_pc_i(if_pc),
      .pred_taken_o(pred_g), .pred_ghr_o(ghr_g),
      .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
      .upd_ghr_i(upd_ghr), .upd_mispredict_i(upd_mis),
      .branch_count_o(bc_g), .mispredict_count_o(mc_g)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: counters as plain integers 0..3, history as an integer 0..15.
   int mb [64];
   int mg [64];
   int mghr;
   int nbr;
   int nmis;

   function automatic int bidx(input logic [31:0] pc);
      return int'((pc >> 2) & 32'd63);
   endfunction

   function automatic int gidx(input logic [31:0] pc, input int h);
      return int'(((pc >> 2) ^ 32'(h)) & 32'd63);
   endfunction

   function automatic int train(input int c, input logic t);
      if (t) return (c < 3) ? c + 1 : c;
      return (c > 0) ? c - 1 : c;
   endfunction

   function automatic int sat15(input int n);
      return (n > 15) ? 15 : n;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) begin
            mb[i] <= 1;
            mg[i] <= 1;
         end
         mghr <= 0;
         nbr  <= 0;
         nmis <= 0;
      end else begin
         if (upd_valid) begin
            mb[bidx(upd_pc)] <= train(mb[bidx(upd_pc)], upd_taken);
            mg[gidx(upd_pc, int'(upd_ghr))] <= train(mg[gidx(upd_pc, int'(upd_ghr))], upd_taken);
            nbr <= nbr + 1;
            if (upd_mis) nmis <= nmis + 1;
         end
         if (upd_valid && upd_mis)
            mghr <= ((int'(upd_ghr) << 1) | int'(upd_taken)) & 15;
         else if (if_valid)
            mghr <= ((mghr << 1) | ((mg[gidx(if_pc, mghr)] >= 2) ? 1 : 0)) & 15;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check("m_pred_b", longint'(pred_b), (mb[bidx(if_pc)] >= 2) ? 1 : 0);
         check("m_pred_g", longint'(pred_g), (mg[gidx(if_pc, mghr)] >= 2) ? 1 : 0);
         check("m_ghr_b", longint'(ghr_b), 0);
         check("m_ghr_g", longint'(ghr_g), mghr);
         check("m_bc_b", longint'(bc_b), sat15(nbr));
         check("m_mc_b", longint'(mc_b), sat15(nmis));
         check("m_bc_g", longint'(bc_g), nbr);
         check("m_mc_g", longint'(mc_g), nmis);
      end
   end

   task automatic drive(input logic iv, input logic [31:0] ipc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [3:0] ug,
                        input logic um);
      if_valid  = iv;
      if_pc     = ipc;
      upd_valid = uv;
      upd_pc    = upc;
      upd_taken = ut;
      upd_ghr   = ug;
      upd_mis   = um;
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 0);
      tick;
      tick;
      #1;
      check("rst_pred_b", longint'(pred_b), 0);
      check("rst_pred_g", longint'(pred_g), 0);
      check("rst_ghr_g", longint'(ghr_g), 0);
      check("rst_bc_b", longint'(bc_b), 0);
      reset  = 1'b0;
      chk_on = 1'b1;
      tick;

      // One taken update: 01 -> 10
      drive(0, 32'h100, 1, 32'h100, 1, 4'h0, 0);
      tick;
      drive(0, 32'h100, 0, 32'h0, 0, 4'h0, 0);
      #1 check("bim_taken1", longint'(pred_b), 1);

      // Saturate at 11, then two not-taken: 10 (pred 1), 01 (pred 0)
      repeat (3) begin
         drive(0, 32'h100, 1, 32'h100, 1, 4'h0, 0);
         tick;
      end
      drive(0, 32'h100, 1, 32'h100, 0, 4'h0, 0);
      tick;
      drive(0, 32'h100, 0, 32'h0, 0, 4'h0, 0);
      #1 check("bim_sat_nt1", longint'(pred_b), 1);
      drive(0, 32'h100, 1, 32'h100, 0, 4'h0, 0);
      tick;
      drive(0, 32'h100, 0, 32'h0, 0, 4'h0, 0);
      #1 check("bim_sat_nt2", longint'(pred_b), 0);

      // 0x200 shares the entry of 0x100; 0x104 does not
      drive(0, 32'h100, 1, 32'h200, 1, 4'h0, 0);
      tick;
      drive(0, 32'h100, 0, 32'h0, 0, 4'h0, 0);
      #1 check("alias_100", longint'(pred_b), 1);
      drive(0, 32'h104, 0, 32'h0, 0, 4'h0, 0);
      #1 check("alias_104", longint'(pred_b), 0);

      // Same-cycle lookup/update at counter 01: no bypass
      drive(0, 32'h100, 1, 32'h100, 0, 4'h0, 0);
      tick;
      drive(0, 32'h100, 1, 32'h100, 1, 4'h0, 0);
      #1 check("coll_same", longint'(pred_b), 0);
      tick;
      drive(0, 32'h100, 0, 32'h0, 0, 4'h0, 0);
      #1 check("coll_next", longint'(pred_b), 1);

      // Gshare: three not-taken predictions, then repair with 0101 + taken
      repeat (3) begin
         drive(1, 32'h40, 0, 32'h0, 0, 4'h0, 0);
         tick;
      end
      drive(1, 32'h40, 1, 32'h40, 1, 4'h5, 1);
      #1 check("ghr_0000", longint'(ghr_g), 0);
      tick;
      drive(1, 32'h40, 0, 32'h0, 0, 4'h0, 0);
      #1 check("ghr_1011", longint'(ghr_g), 11);
      tick;
      drive(1, 32'h44, 0, 32'h0, 0, 4'h0, 0);
      tick;
      drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 0);
      tick;

      // 20 mispredicted updates saturate the 4-bit counters
      for (int i = 0; i < 20; i++) begin
         drive(0, 32'h300, 1, 32'h300 + 32'(4 * (i % 4)), logic'(i % 2), 4'h0, 1);
         tick;
      end
      drive(0, 32'h300, 0, 32'h0, 0, 4'h0, 0);
      #1;
      check("bc_sat15", longint'(bc_b), 15);
      check("mc_sat15", longint'(mc_b), 15);
      tick;

      // Asynchronous reset mid-sequence clears before the next edge
      repeat (2) begin
         drive(0, 32'h100, 1, 32'h100, 1, 4'h0, 1);
         tick;
      end
      #2 reset = 1'b1;
      #1;
      check("arst_bc", longint'(bc_b), 0);
      check("arst_mc", longint'(mc_b), 0);
      check("arst_ghr", longint'(ghr_g), 0);
      tick;
      tick;

      // Update in the cycle reset deasserts is applied
      reset = 1'b0;
      drive(0, 32'h100, 1, 32'h100, 1, 4'h0, 0);
      tick;
      drive(0, 32'h100, 0, 32'h0, 0, 4'h0, 0);
      #1;
      check("post_rst_bc", longint'(bc_b), 1);
      check("post_rst_pred", longint'(pred_b), 1);
      tick;
      tick;

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
